// File: rtl/qos_arbiter_if.sv
`default_nettype none
// qos_arbiter_if: push/pop bus and per-channel status of qos_arbiter.
// Define QOS_WRR_EN to carry the per-channel WEIGHTS field. Rev 1.0
interface qos_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  localparam int NCH = 2**CH_W;

  logic [DATA_W-1:0] DATA_IN;
  logic              WRITE;
  logic [CH_W-1:0]   WR_ID;
  logic              OUT_READY;
  logic [DATA_W-1:0] DATA_OUT;
  logic              VALID_OUT;
  logic [CH_W-1:0]   POP_ID;
  logic [NCH-1:0]    EMPTY;
  logic [NCH-1:0]    FULL;
  logic [NCH-1:0]    PAUSE;
  logic              ERR_OVERFLOW;
`ifdef QOS_WRR_EN
  logic [4*NCH-1:0]  WEIGHTS;

  modport slave (
    input  DATA_IN, WRITE, WR_ID, OUT_READY, WEIGHTS,
    output DATA_OUT, VALID_OUT, POP_ID, EMPTY, FULL, PAUSE, ERR_OVERFLOW
  );
  modport master (
    output DATA_IN, WRITE, WR_ID, OUT_READY, WEIGHTS,
    input  DATA_OUT, VALID_OUT, POP_ID, EMPTY, FULL, PAUSE, ERR_OVERFLOW
  );
`else
  modport slave (
    input  DATA_IN, WRITE, WR_ID, OUT_READY,
    output DATA_OUT, VALID_OUT, POP_ID, EMPTY, FULL, PAUSE, ERR_OVERFLOW
  );
  modport master (
    output DATA_IN, WRITE, WR_ID, OUT_READY,
    input  DATA_OUT, VALID_OUT, POP_ID, EMPTY, FULL, PAUSE, ERR_OVERFLOW
  );
`endif
endinterface
`default_nettype wire

// File: rtl/qos_arbiter.sv
`default_nettype none
// qos_arbiter: per-channel FIFOs feeding a registered round-robin output stage.
// Define QOS_WRR_EN for weighted round-robin driven by WEIGHTS. Rev 1.0
module qos_arbiter #(
  parameter int DATA_W  = 8,
  parameter int CH_W    = 2,
  parameter int DEPTH_W = 3,
  parameter int AF_TH   = 6,
  parameter int AE_TH   = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  qos_arbiter_if.slave bus
);
  localparam int               NCH     = 2**CH_W;
  localparam logic [DEPTH_W:0] C_DEPTH = (DEPTH_W+1)'(2**DEPTH_W);
  localparam logic [DEPTH_W:0] C_AF    = (DEPTH_W+1)'(AF_TH);
  localparam logic [DEPTH_W:0] C_AE    = (DEPTH_W+1)'(AE_TH);
  localparam logic [CH_W-1:0]  C_LAST  = CH_W'(NCH-1);

  logic [NCH-1:0]    nonempty_w;
  logic [NCH-1:0]    full_w;
  logic [NCH-1:0]    push_w;
  logic [NCH-1:0]    pop_w;
  logic [DATA_W-1:0] rd_w [NCH];

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [CH_W-1:0]   pop_id_q;
  logic [CH_W-1:0]   last_q;
  logic              err_q;

  logic              load_w;
  logic              stay_w;
  logic              grant_vld_w;
  logic [CH_W-1:0]   grant_w;

  assign load_w = !valid_q || bus.OUT_READY;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DATA_W-1:0]  mem_q [2**DEPTH_W];
    logic [DEPTH_W:0]   cnt_q;
    logic [DEPTH_W:0]   cnt_d;
    logic [DEPTH_W-1:0] wptr_q;
    logic [DEPTH_W-1:0] rptr_q;
    logic               pause_q;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
    assign nonempty_w[i]  = (cnt_q != '0);
    assign full_w[i]      = (cnt_q == C_DEPTH);
    assign push_w[i]      = bus.WRITE && (bus.WR_ID == CH_W'(i)) && !full_w[i];
    assign pop_w[i]       = load_w && grant_vld_w && (grant_w == CH_W'(i));
    assign rd_w[i]        = mem_q[rptr_q];
    assign bus.EMPTY[i]   = !nonempty_w[i];
    assign bus.FULL[i]    = full_w[i];
    assign bus.PAUSE[i]   = pause_q;

    always_comb begin
      cnt_d = cnt_q;
      if (push_w[i] && !pop_w[i]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!push_w[i] && pop_w[i]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        cnt_q   <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
        pause_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (push_w[i]) wptr_q <= wptr_q + 1'b1;
        if (pop_w[i])  rptr_q <= rptr_q + 1'b1;
        if (cnt_d >= C_AF) begin
          pause_q <= 1'b1;
        end else if (cnt_d <= C_AE) begin
          pause_q <= 1'b0;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (push_w[i]) mem_q[wptr_q] <= bus.DATA_IN;
    end
  end

`ifdef QOS_WRR_EN
  // burst_q counts pops already given to last_q; its reset value forces a fresh search.
  logic [3:0] burst_q;
  logic [3:0] wt_raw_w;
  logic [3:0] wt_w;

  assign wt_raw_w = bus.WEIGHTS[{last_q, 2'b00} +: 4];
  assign wt_w     = (wt_raw_w == 4'd0) ? 4'd1 : wt_raw_w;
  assign stay_w   = nonempty_w[last_q] && (burst_q < wt_w);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      burst_q <= 4'hF;
    end else if (load_w && grant_vld_w) begin
      burst_q <= stay_w ? (burst_q + 1'b1) : 4'd1;
    end
  end
`else
  assign stay_w = 1'b0;
`endif

  always_comb begin
    grant_vld_w = 1'b0;
    grant_w     = last_q;
    if (stay_w) begin
      grant_vld_w = 1'b1;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        if (!grant_vld_w && nonempty_w[last_q + CH_W'(k)]) begin
          grant_vld_w = 1'b1;
          grant_w     = last_q + CH_W'(k);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      pop_id_q <= '0;
      last_q   <= C_LAST;
      err_q    <= 1'b0;
    end else begin
      if (bus.WRITE && full_w[bus.WR_ID]) err_q <= 1'b1;
      if (load_w) begin
        valid_q <= grant_vld_w;
        if (grant_vld_w) begin
          data_q   <= rd_w[grant_w];
          pop_id_q <= grant_w;
          last_q   <= grant_w;
        end
      end
    end
  end

  assign bus.DATA_OUT     = data_q;
  assign bus.VALID_OUT    = valid_q;
  assign bus.POP_ID       = pop_id_q;
  assign bus.ERR_OVERFLOW = err_q;
endmodule
`default_nettype wire

// File: tb/tb_qos_arbiter.sv
`default_nettype none
// tb_qos_arbiter: directed and randomized checks of qos_arbiter against a queue-based model.
module tb_qos_arbiter;
  localparam int DATA_W = 8, CH_W = 2, DEPTH_W = 3, AF_TH = 6, AE_TH = 2;
  localparam int NCH = 4, DEPTH = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  qos_arbiter_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  qos_arbiter #(
    .DATA_W(DATA_W), .CH_W(CH_W), .DEPTH_W(DEPTH_W), .AF_TH(AF_TH), .AE_TH(AE_TH)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // Model state: one queue per channel plus the output register contents.
  logic [7:0] mq [NCH][$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id, m_last, m_burst;
  bit         m_err;
  bit [NCH-1:0] m_pause;

`ifdef QOS_WRR_EN
  int exp_rr[8]  = '{0, 0, 1, 2, 3, 1, 2, 3};
  int exp_wrr[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
`else
  int exp_rr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  g, id;
    bit  ld, full_pre;
    if (RESET) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_valid = 0; m_data = '0; m_id = 0; m_last = NCH - 1; m_burst = 15;
      m_err = 0; m_pause = '0;
      return;
    end
    ld       = !m_valid || bus.OUT_READY;
    g        = -1;
    id       = int'(bus.WR_ID);
    full_pre = (mq[id].size() == DEPTH);
    if (ld) begin
`ifdef QOS_WRR_EN
      begin
        int w = int'(bus.WEIGHTS[m_last*4 +: 4]);
        if (w == 0) w = 1;
        if (mq[m_last].size() > 0 && m_burst < w) begin
          g = m_last;
          m_burst++;
        end
      end
`endif
      if (g < 0) begin
        for (int k = 1; k <= NCH; k++) begin
          int c = (m_last + k) % NCH;
          if (g < 0 && mq[c].size() > 0) begin
            g = c;
            m_burst = 1;
          end
        end
      end
      if (g >= 0) begin
        m_data  = mq[g].pop_front();
        m_id    = g;
        m_last  = g;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (bus.WRITE) begin
      if (full_pre) m_err = 1;
      else mq[id].push_back(bus.DATA_IN);
    end
    for (int c = 0; c < NCH; c++) begin
      if (mq[c].size() >= AF_TH) m_pause[c] = 1;
      else if (mq[c].size() <= AE_TH) m_pause[c] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive(bit wr, int id, int d, bit rdy);
    bus.WRITE     = wr;
    bus.WR_ID     = CH_W'(id);
    bus.DATA_IN   = DATA_W'(d);
    bus.OUT_READY = rdy;
  endtask

  task automatic reset_dut();
    drive(0, 0, 0, 0);
    RESET = 1;
    cycle();
    RESET = 0;
  endtask

  always @(negedge CLK) begin : cmp
    logic [NCH-1:0] e, f;
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        e[c] = (mq[c].size() == 0);
        f[c] = (mq[c].size() == DEPTH);
      end
      chk("valid", bus.VALID_OUT, m_valid);
      if (m_valid) begin
        chk("data", bus.DATA_OUT, m_data);
        chk("pop_id", bus.POP_ID, m_id);
      end
      chk("empty", bus.EMPTY, e);
      chk("full", bus.FULL, f);
      chk("pause", bus.PAUSE, m_pause);
      chk("err", bus.ERR_OVERFLOW, m_err);
    end
  end

  initial begin
    drive(0, 0, 0, 0);
`ifdef QOS_WRR_EN
    bus.WEIGHTS = 16'h0013;
`endif
    RESET = 1;
    cycle();
    cycle();
    chk_en = 1;
    chk("rst_valid", bus.VALID_OUT, 0);
    chk("rst_data", bus.DATA_OUT, 0);
    chk("rst_popid", bus.POP_ID, 0);
    chk("rst_empty", bus.EMPTY, 4'hF);
    chk("rst_full", bus.FULL, 0);
    chk("rst_pause", bus.PAUSE, 0);
    chk("rst_err", bus.ERR_OVERFLOW, 0);

    // Single word latency
    RESET = 0;
    drive(1, 0, 'hA1, 1);
    cycle();
    chk("lat_t0_valid", bus.VALID_OUT, 0);
    drive(0, 0, 0, 1);
    cycle();
    chk("lat_valid", bus.VALID_OUT, 1);
    chk("lat_data", bus.DATA_OUT, 8'hA1);
    chk("lat_popid", bus.POP_ID, 0);
    cycle();
    chk("lat_idle", bus.VALID_OUT, 0);

    // Round-robin order over two words per channel
    reset_dut();
    for (int n = 0; n < 8; n++) begin
      drive(1, n % 4, 'h10 + n, 0);
      cycle();
    end
    drive(0, 0, 0, 1);
    begin
      int got = 0, budget = 0;
      while (got < 8 && budget < 40) begin
        if (bus.VALID_OUT) begin
          chk("rr_order", bus.POP_ID, exp_rr[got]);
          got++;
        end
        cycle();
        budget++;
      end
      chk("rr_count", got, 8);
      chk("rr_drained", bus.VALID_OUT, 0);
    end

    // Overflow: output stage occupied by ch0, then nine pushes to ch2
    reset_dut();
    drive(1, 0, 'h55, 0);
    cycle();
    for (int n = 0; n < 9; n++) begin
      drive(1, 2, 'h20 + n, 0);
      cycle();
      if (n == 7) begin
        chk("ovf_full8", bus.FULL[2], 1);
        chk("ovf_err_pre", bus.ERR_OVERFLOW, 0);
      end
    end
    chk("ovf_err", bus.ERR_OVERFLOW, 1);
    chk("ovf_fullvec", bus.FULL, 4'b0100);
    drive(0, 0, 0, 1);
    repeat (3) cycle();
    chk("ovf_sticky", bus.ERR_OVERFLOW, 1);
    reset_dut();
    chk("ovf_cleared", bus.ERR_OVERFLOW, 0);

    // Pause hysteresis on ch1
    drive(1, 0, 'h77, 0);
    cycle();
    for (int n = 0; n < 6; n++) begin
      drive(1, 1, 'h30 + n, 0);
      cycle();
      if (n == 4) chk("pause_at5", bus.PAUSE[1], 0);
    end
    chk("pause_at6", bus.PAUSE[1], 1);
    drive(0, 0, 0, 1);
    begin
      int budget = 0;
      while (mq[1].size() > 2 && budget < 20) begin
        cycle();
        budget++;
        if (mq[1].size() == 3) chk("pause_at3", bus.PAUSE[1], 1);
      end
      chk("drain_bound", mq[1].size(), 2);
      chk("pause_at2", bus.PAUSE[1], 0);
    end

    // Backpressure hold, then reset mid-transfer with a write asserted
    reset_dut();
    drive(1, 3, 'h5C, 0);
    cycle();
    drive(1, 1, 'h99, 0);
    cycle();
    drive(0, 0, 0, 0);
    repeat (5) begin
      cycle();
      chk("hold_valid", bus.VALID_OUT, 1);
      chk("hold_data", bus.DATA_OUT, 8'h5C);
      chk("hold_id", bus.POP_ID, 3);
    end
    drive(1, 2, 'hEE, 1);
    RESET = 1;
    cycle();
    RESET = 0;
    drive(0, 0, 0, 1);
    chk("rstmid_valid", bus.VALID_OUT, 0);
    chk("rstmid_empty", bus.EMPTY, 4'hF);
    cycle();
    chk("rstmid_nowrite", bus.EMPTY, 4'hF);
    chk("rstmid_idle", bus.VALID_OUT, 0);

`ifdef QOS_WRR_EN
    // Weighted order with ch0 weight 3, ch1 weight 1
    reset_dut();
    for (int n = 0; n < 8; n++) begin
      drive(1, n % 2, 'h40 + n, 0);
      cycle();
    end
    drive(0, 0, 0, 1);
    begin
      int got = 0, budget = 0;
      while (got < 8 && budget < 40) begin
        if (bus.VALID_OUT) begin
          chk("wrr_order", bus.POP_ID, exp_wrr[got]);
          got++;
        end
        cycle();
        budget++;
      end
      chk("wrr_count", got, 8);
    end
`endif

    // Randomized traffic with varying backpressure and occasional reset
    reset_dut();
    for (int n = 0; n < 4000; n++) begin
      RESET = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 99) < ((n % 1000) < 500 ? 30 : 80));
      cycle();
    end
    RESET = 0;
    drive(0, 0, 0, 1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/qos_arbiter.md
QOS_ARBITER -- requirements
Module: qos_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 SHALL have parameter CH_W, default 2, meaning channel-index width; NCH = 2**CH_W channels.
REQ-003 SHALL have parameter DEPTH_W, default 3, meaning per-channel FIFO depth DEPTH = 2**DEPTH_W words.
REQ-004 SHALL have parameter AF_TH, default 6, meaning pause-assert occupancy threshold.
REQ-005 SHALL have parameter AE_TH, default 2, meaning pause-release occupancy threshold (AE_TH < AF_TH <= DEPTH).
REQ-006 SHALL have port CLK  in  1  meaning the single clock; all logic on rising edge.
REQ-007 SHALL have port RESET  in  1  meaning synchronous, active-high reset.
REQ-008 SHALL have port DATA_IN  in  DATA_W  meaning write data.
REQ-009 SHALL have port WRITE  in  1  meaning push DATA_IN into channel WR_ID.
REQ-010 SHALL have port WR_ID  in  CH_W  meaning destination channel of a push.
REQ-011 SHALL have port OUT_READY  in  1  meaning downstream accepts DATA_OUT this cycle.
REQ-012 SHALL have port DATA_OUT  out  DATA_W  meaning registered arbitrated output word.
REQ-013 SHALL have port VALID_OUT  out  1  meaning DATA_OUT holds a word.
REQ-014 SHALL have port POP_ID  out  CH_W  meaning source channel of DATA_OUT.
REQ-015 SHALL have ports EMPTY, FULL, PAUSE  out  NCH each  meaning per-channel empty, full, flow-control pause.
REQ-016 SHALL have port ERR_OVERFLOW  out  1  meaning sticky: a push to a full channel occurred.

Function
REQ-017 Push with WRITE=1 to non-full channel SHALL store DATA_IN at that edge; push to full channel SHALL be dropped and set ERR_OVERFLOW.
REQ-018 Full-channel push SHALL be dropped even if the same channel is popped in that cycle.
REQ-019 Output stage SHALL load when VALID_OUT=0 or OUT_READY=1; otherwise DATA_OUT, POP_ID, VALID_OUT hold.
REQ-020 On load, arbiter SHALL grant the first non-empty channel searching from (last grant + 1) mod NCH, pop one word, register it with VALID_OUT=1 next cycle.
REQ-021 If no channel is non-empty at load, VALID_OUT SHALL go 0; last-grant pointer unchanged.
REQ-022 Latency: word pushed at edge t into an idle, empty block SHALL appear with VALID_OUT=1 after edge t+1.
REQ-023 A channel pushed and empty in the same cycle SHALL not be popped that cycle.
REQ-024 Per-channel occupancy counters SHALL be DEPTH_W+1 bits; pointers wrap modulo DEPTH; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 PAUSE[i] SHALL set when occupancy >= AF_TH and clear when occupancy <= AE_TH; between thresholds it holds (hysteresis).
REQ-026 EMPTY/FULL SHALL reflect occupancy 0 / DEPTH after each edge.

Reset
REQ-027 RESET=1 at a rising edge SHALL empty all FIFOs, set VALID_OUT=0, DATA_OUT=0, POP_ID=0, PAUSE=0, ERR_OVERFLOW=0, EMPTY=all 1, FULL=0, last-grant pointer = NCH-1.
REQ-028 Reset mid-transfer SHALL discard held and stored words; WRITE during reset SHALL be ignored.

Configuration
REQ-029 With QOS_WRR_EN defined, SHALL add input WEIGHTS (4*NCH bits, 4 per channel) and grant each channel up to max(WEIGHTS[i],1) consecutive pops before advancing, advancing early when it empties.
REQ-030 Without QOS_WRR_EN, port WEIGHTS SHALL not exist and each grant SHALL be one pop (plain round-robin).

Verification
REQ-031 Reset, push 0xA1 to ch0, OUT_READY=1 -> next cycle VALID_OUT=1, DATA_OUT=0xA1, POP_ID=0.
REQ-032 Push 2 words each to ch0..ch3, OUT_READY=1 -> POP_ID order 0,1,2,3,0,1,2,3, then VALID_OUT=0.
REQ-033 Push 9 words to ch2 with OUT_READY=0 (DEPTH=8) -> FULL[2]=1, 9th dropped, ERR_OVERFLOW=1 until RESET.
REQ-034 Fill ch1 to 6 -> PAUSE[1]=1; drain to 3 -> still 1; drain to 2 -> PAUSE[1]=0.
REQ-035 Hold OUT_READY=0 with VALID_OUT=1 for 5 cycles -> DATA_OUT/POP_ID stable; pulse RESET -> VALID_OUT=0, all EMPTY=1.
REQ-036 QOS_WRR_EN, WEIGHTS ch0=3 ch1=1, both with 4 words -> POP_ID 0,0,0,1,0,1,1,1.
